seg_scan_arbiter: RTL and testbench

Controller for the 4-digit multiplexed seven-segment display. It owns the 4×4-bit digit buffer and shares write access between two requesters (e.g. the CPU bus and the button counter) with a round-robin arbiter. It also sequences the digit scan at a selectable refresh rate, with an optional blanking gap between digits. It sits between the requesters and the board's grounds/segment pins.

---
 rtl/seg_scan_arbiter_pkg.sv | 23 ++
 rtl/seg_scan_arbiter_if.sv | 28 ++
 rtl/seg_scan_arbiter_hex7seg.sv | 11 +
 rtl/seg_scan_arbiter.sv | 153 +++++++++++++++
 tb/tb_seg_scan_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_arbiter_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// The segment table is also consumed by the existing display module.
package seg_pkg;

  typedef enum logic [0:0] {SHOW, BLANK} scan_state_t;

  typedef logic [3:0] digit_t;

  localparam logic [3:0] GROUNDS_RESET = 4'b1110;

  // Segments a..g, bit 6 = a, active-high; indexed by hex value
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  function automatic logic [6:0] seg_decode(input digit_t hex);
    return SEG_LUT[hex];
  endfunction

endpackage

// File: rtl/seg_scan_arbiter_if.sv
// Write-request bundle for the two requesters sharing the digit buffer.
// master = requester side, slave = controller side.
interface seg_scan_arbiter_if;
  import seg_pkg::*;

  logic       req0_valid;
  logic [1:0] req0_digit;
  digit_t     req0_data;
  logic       req0_ready;

  logic       req1_valid;
  logic [1:0] req1_digit;
  digit_t     req1_data;
  logic       req1_ready;

  modport master (
    output req0_valid, req0_digit, req0_data,
    output req1_valid, req1_digit, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_digit, req0_data,
    input  req1_valid, req1_digit, req1_data,
    output req0_ready, req1_ready
  );

endinterface

// File: rtl/seg_scan_arbiter_hex7seg.sv
// Combinational hex to seven-segment decoder (bit 6 = segment a).
module hex7seg
  import seg_pkg::*;
(
  input  digit_t     i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = seg_decode(i_hex);

endmodule

// File: rtl/seg_scan_arbiter.sv
// 4-digit display controller: round-robin write arbiter, digit buffer and scan FSM.
// Define SEG_BLANK_EN to insert BLANK_CYCLES of all-off between digits.
module seg_scan_arbiter
  import seg_pkg::*;
#(
  parameter int unsigned PRESC_W      = 26,
  parameter int unsigned RATE0_BIT    = 15,
  parameter int unsigned RATE1_BIT    = 19,
  parameter int unsigned RATE2_BIT    = 25,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          rate_sel,
  seg_scan_arbiter_if.slave   req,
  output logic [3:0]          grounds,
  output logic [6:0]          display,
  output logic                dp
);

  if (RATE0_BIT >= PRESC_W || RATE1_BIT >= PRESC_W || RATE2_BIT >= PRESC_W) begin : g_bad_rate
    $error("RATEn_BIT must be below PRESC_W");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("BLANK_CYCLES must be at least 1");
  end

  // Prescaler and tick detection
  logic [PRESC_W-1:0] r_presc;
  logic               r_sel_bit;
  logic               w_sel_bit;
  logic               w_tick;

  always_comb begin
    case (rate_sel)
      2'd1:    w_sel_bit = r_presc[RATE1_BIT];
      2'd2:    w_sel_bit = r_presc[RATE2_BIT];
      default: w_sel_bit = r_presc[RATE0_BIT];
    endcase
  end

  // Comparing against the copy of whichever bit was selected last cycle allows
  // at most one spurious tick when rate_sel changes.
  assign w_tick = w_sel_bit & ~r_sel_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc   <= '0;
      r_sel_bit <= 1'b0;
    end else begin
      r_presc   <= r_presc + PRESC_W'(1);
      r_sel_bit <= w_sel_bit;
    end
  end

  // Round-robin arbiter: r_last is the requester granted most recently
  logic r_last;
  logic w_grant0;
  logic w_grant1;

  assign w_grant0       = req.req0_valid & (~req.req1_valid | r_last);
  assign w_grant1       = req.req1_valid & (~req.req0_valid | ~r_last);
  assign req.req0_ready = w_grant0;
  assign req.req1_ready = w_grant1;

  digit_t r_buf [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_grant0) begin
      r_last                 <= 1'b0;
      r_buf[req.req0_digit]  <= req.req0_data;
    end else if (w_grant1) begin
      r_last                 <= 1'b1;
      r_buf[req.req1_digit]  <= req.req1_data;
    end
  end

  // Scan FSM
  scan_state_t r_state;
  scan_state_t w_state_nxt;
  logic [1:0]  r_idx;
  logic [1:0]  w_idx_nxt;

`ifdef SEG_BLANK_EN
  localparam int unsigned BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  logic [BLANK_W-1:0] r_blank_cnt;
  logic [BLANK_W-1:0] w_blank_cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blank_cnt <= '0;
    end else begin
      r_blank_cnt <= w_blank_cnt_nxt;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SHOW;
      r_idx   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
`ifdef SEG_BLANK_EN
    w_blank_cnt_nxt = r_blank_cnt;
`endif
    grounds = ~(4'b0001 << r_idx);
    case (r_state)
      SHOW: begin
        if (w_tick) begin
`ifdef SEG_BLANK_EN
          w_state_nxt     = BLANK;
          w_blank_cnt_nxt = BLANK_W'(BLANK_CYCLES - 1);
`else
          w_idx_nxt = r_idx + 2'd1;
`endif
        end
      end
`ifdef SEG_BLANK_EN
      BLANK: begin
        grounds = 4'b1111;
        if (r_blank_cnt == '0) begin
          w_idx_nxt   = r_idx + 2'd1;
          w_state_nxt = SHOW;
        end else begin
          w_blank_cnt_nxt = r_blank_cnt - BLANK_W'(1);
        end
      end
`endif
      default: w_state_nxt = SHOW;
    endcase
  end

  hex7seg u_hex7seg (
    .i_hex (r_buf[r_idx]),
    .o_seg (display)
  );

  assign dp = 1'b0;

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Self-checking bench for seg_scan_arbiter with a small prescaler; honours SEG_BLANK_EN.
module tb_seg_scan_arbiter;

  localparam int unsigned PW  = 10;
  localparam int unsigned R0  = 3;
  localparam int unsigned R1  = 5;
  localparam int unsigned R2  = 8;
  localparam int unsigned BLK = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] rate_sel;
  logic [3:0] grounds;
  logic [6:0] display;
  logic       dp;

  seg_scan_arbiter_if u_if ();

  seg_scan_arbiter #(
    .PRESC_W      (PW),
    .RATE0_BIT    (R0),
    .RATE1_BIT    (R1),
    .RATE2_BIT    (R2),
    .BLANK_CYCLES (BLK)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .rate_sel (rate_sel),
    .req      (u_if),
    .grounds  (grounds),
    .display  (display),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [3:0] exp_buf [4];
  logic       m_last;
  logic [3:0] cur_g;
  logic [1:0] rdy_q [$];

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;  default: return 7'b1000111;
    endcase
  endfunction

  function automatic int g2idx(input logic [3:0] g);
    case (g)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic clear_reqs();
    u_if.req0_valid = 1'b0; u_if.req0_digit = 2'd0; u_if.req0_data = 4'h0;
    u_if.req1_valid = 1'b0; u_if.req1_digit = 2'd0; u_if.req1_data = 4'h0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) exp_buf[i] = 4'h0;
    m_last = 1'b1;
    cur_g  = 4'b1110;
    rdy_q.delete();
  endtask

  // Waits for the next SHOW step (a new non-blank grounds value)
  task automatic wait_step(input int budget, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      @(negedge clk);
      n++;
      if (grounds != 4'b1111 && grounds != cur_g) begin
        ok    = 1'b1;
        cur_g = grounds;
      end
    end
  endtask

  // Drives one request cycle and pushes the expected grants
  task automatic drive_req(input logic v0, input logic [1:0] d0, input logic [3:0] x0,
                           input logic v1, input logic [1:0] d1, input logic [3:0] x1);
    logic e0, e1;
    u_if.req0_valid = v0; u_if.req0_digit = d0; u_if.req0_data = x0;
    u_if.req1_valid = v1; u_if.req1_digit = d1; u_if.req1_data = x1;
    e0 = v0 && (!v1 || m_last);
    e1 = v1 && (!v0 || !m_last);
    rdy_q.push_back({e0, e1});
    if (e0) begin
      exp_buf[d0] = x0; m_last = 1'b0;
    end else if (e1) begin
      exp_buf[d1] = x1; m_last = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_reqs();
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rate_sel = 2'd0;
    clear_reqs();
    repeat (2) @(negedge clk);
    checks++;
    if (grounds !== 4'b1110) begin
      errors++; $display("FAIL reset_grounds: got %b want 1110", grounds);
    end
    checks++;
    if (display !== 7'b1111110) begin
      errors++; $display("FAIL reset_display: got %b want 1111110", display);
    end
    checks++;
    if (dp !== 1'b0) begin
      errors++; $display("FAIL reset_dp: got %b want 0", dp);
    end
    model_reset();
    rst = 1'b0;
    #1;
    checks++;
    if (grounds !== 4'b1110 || display !== 7'b1111110) begin
      errors++; $display("FAIL release_idle: got %b/%b want 1110/1111110", grounds, display);
    end
  endtask

  task automatic test_single_write();
    logic [1:0] r;
    drive_req(1'b1, 2'd0, 4'hA, 1'b0, 2'd0, 4'h0);
    #1;
    r = rdy_q.pop_front();
    checks++;
    if ({u_if.req0_ready, u_if.req1_ready} !== r) begin
      errors++;
      $display("FAIL single_ready: got %b%b want %b", u_if.req0_ready, u_if.req1_ready, r);
    end
    @(negedge clk);
    clear_reqs();
    checks++;
    if (grounds !== 4'b1110 || display !== 7'b1110111) begin
      errors++; $display("FAIL single_display: got %b/%b want 1110/1110111", grounds, display);
    end
  endtask

  task automatic test_first_step();
    int n; bit ok;
    wait_step(60, n, ok);
    checks++;
    if (!ok || grounds !== 4'b1101) begin
      errors++; $display("FAIL first_step: got %b ok=%0d want 1101", grounds, ok);
    end
  endtask

  task automatic test_scan_contents(input string name);
    int n; bit ok; int idx;
    for (int k = 0; k < 4; k++) begin
      wait_step(2000, n, ok);
      idx = g2idx(grounds);
      checks++;
      if (!ok || idx < 0) begin
        errors++; $display("FAIL %s_step%0d: grounds %b ok=%0d", name, k, grounds, ok);
      end else if (display !== glyph(exp_buf[idx]) || dp !== 1'b0) begin
        errors++;
        $display("FAIL %s_digit%0d: got %b dp=%b want %b", name, idx, display, dp,
                 glyph(exp_buf[idx]));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] r;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b1, 2'd1, 4'h5, 1'b1, 2'd2, 4'hC);
      #1;
      r = rdy_q.pop_front();
      checks++;
      if ({u_if.req0_ready, u_if.req1_ready} !== r
          || u_if.req0_ready !== ((i % 2) == 0)) begin
        errors++;
        $display("FAIL b2b_grant%0d: got %b%b want %b", i, u_if.req0_ready, u_if.req1_ready, r);
      end
      @(negedge clk);
    end
    clear_reqs();
    test_scan_contents("b2b");
  endtask

  task automatic test_blank();
    int n;
`ifdef SEG_BLANK_EN
    logic [3:0] nxt;
    n = 0;
    while (n < 60 && grounds !== 4'b1111) begin
      @(negedge clk); n++;
    end
    n = 0;
    while (n < 40 && grounds === 4'b1111) begin
      @(negedge clk); n++;
    end
    nxt = {cur_g[2:0], cur_g[3]};
    checks++;
    if (n != BLK || grounds !== nxt) begin
      errors++; $display("FAIL blank_len: got %0d cycles then %b want %0d then %b",
                         n, grounds, BLK, nxt);
    end
    cur_g = grounds;
`else
    n = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (grounds === 4'b1111) n++;
    end
    checks++;
    if (n != 0) begin
      errors++; $display("FAIL no_blank: got %0d all-off cycles want 0", n);
    end
    cur_g = grounds;
`endif
  endtask

  task automatic test_rate();
    int n; bit ok;
    int exp_n [4];
    logic [1:0] sel [4];
    sel[0] = 2'd0; sel[1] = 2'd1; sel[2] = 2'd2; sel[3] = 2'd3;
    exp_n[0] = 1 << (R0 + 1); exp_n[1] = 1 << (R1 + 1);
    exp_n[2] = 1 << (R2 + 1); exp_n[3] = 1 << (R0 + 1);
    for (int s = 0; s < 4; s++) begin
      rate_sel = sel[s];
      wait_step(2 * exp_n[s] + 64, n, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL rate%0d_first: no step within %0d cycles", s, n);
      end
      wait_step(2 * exp_n[s] + 64, n, ok);
      wait_step(2 * exp_n[s] + 64, n, ok);
      checks++;
      if (!ok || n != exp_n[s]) begin
        errors++; $display("FAIL rate%0d_period: got %0d ok=%0d want %0d", s, n, ok, exp_n[s]);
      end
    end
    rate_sel = 2'd0;
  endtask

  task automatic test_reset_mid();
    int n;
    bit ok;
    ok = 1'b1;
`ifdef SEG_BLANK_EN
    n = 0;
    while (n < 60 && grounds !== 4'b1111) begin
      @(negedge clk); n++;
    end
    ok = (grounds === 4'b1111);
`else
    n = 0;
    @(negedge clk);
`endif
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rst_mid_blank: got %b want 1111 before reset", grounds);
    end
    u_if.req0_valid = 1'b1; u_if.req0_digit = 2'd3; u_if.req0_data = 4'h7;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (grounds !== 4'b1110 || display !== 7'b1111110) begin
      errors++; $display("FAIL rst_mid_async: got %b/%b want 1110/1111110", grounds, display);
    end
    clear_reqs();
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b0;
    test_scan_contents("rst_mid");
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_first_step();
    test_back_to_back();
    test_blank();
    test_rate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
